// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer fed by a framed byte stream
// (4-byte LE word count, N LE payload words, 1-byte payload checksum).
module imem_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic                  Byte_Valid,
    input  logic [7:0]            Byte_Data,
    output logic                  Byte_Ready,
    output logic                  IMEM_W_En,
    output logic [ADDR_WIDTH-1:0] IMEM_W_Addr,
    output logic [31:0]           IMEM_W_Data,
    output logic                  Core_Hold_En,
    output logic                  Load_Done,
    output logic                  Load_Err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;

    state_t              state;
    logic [31:0]         sh, len, nxt;
    logic [1:0]          bcnt;
    logic [ADDR_WIDTH:0] widx;
    logic [7:0]          csum;
    logic [TW-1:0]       tmo;
    logic                busy, take, expired;

    assign busy         = state == LEN || state == DATA || state == CSUM;
    assign take         = Byte_Valid && busy;
    assign nxt          = {Byte_Data, sh[31:8]};
    assign expired      = busy && !take && 32'(tmo) + 32'd1 == 32'(TIMEOUT_CYCLES);
    assign Byte_Ready   = busy;
    assign Core_Hold_En = busy || state == ERROR;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            sh          <= '0;
            len         <= '0;
            bcnt        <= '0;
            widx        <= '0;
            csum        <= '0;
            tmo         <= '0;
            IMEM_W_En   <= 1'b0;
            IMEM_W_Addr <= '0;
            IMEM_W_Data <= '0;
            Load_Done   <= 1'b0;
            Load_Err    <= 1'b0;
        end else begin
            IMEM_W_En <= 1'b0;
            if (take) begin
                sh   <= nxt;
                bcnt <= bcnt + 2'd1;
                tmo  <= '0;
            end else if (busy) begin
                tmo <= tmo + 1'b1;
            end
            case (state)
                IDLE, DONE, ERROR: if (Start) begin
                    state     <= LEN;
                    Load_Done <= 1'b0;
                    Load_Err  <= 1'b0;
                    csum      <= '0;
                    widx      <= '0;
                    tmo       <= '0;
                    bcnt      <= '0;
                end
                LEN: if (take && bcnt == 2'd3) begin
                    len      <= nxt;
                    state    <= nxt == 32'd0 ? CSUM : {1'b0, nxt} > DEPTH ? ERROR : DATA;
                    Load_Err <= {1'b0, nxt} > DEPTH;
                end
                DATA: if (take) begin
                    csum <= csum + Byte_Data;
                    if (bcnt == 2'd3) begin
                        IMEM_W_En   <= 1'b1;
                        IMEM_W_Addr <= widx[ADDR_WIDTH-1:0];
                        IMEM_W_Data <= nxt;
                        widx        <= widx + 1'b1;
                        if (32'(widx) + 32'd1 == len) state <= CSUM;
                    end
                end
                CSUM: if (take) begin
                    state     <= Byte_Data == csum ? DONE : ERROR;
                    Load_Done <= Byte_Data == csum;
                    Load_Err  <= Byte_Data != csum;
                end
                default: ;
            endcase
            // a byte accepted this cycle takes priority over the idle timeout
            if (expired) begin
                state    <= ERROR;
                Load_Err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized frames against a frame-level reference
// model (expected memory image and checksum built from the words sent).
module tb_imem_loader;
    localparam int AW  = 10;
    localparam int TMO = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Start = 1'b0;
    logic          Byte_Valid = 1'b0;
    logic [7:0]    Byte_Data = '0;
    logic          Byte_Ready, IMEM_W_En, Core_Hold_En, Load_Done, Load_Err;
    logic [AW-1:0] IMEM_W_Addr;
    logic [31:0]   IMEM_W_Data;

    int tests = 0, fails = 0, pulses = 0;
    logic [31:0] obs_mem [int];
    logic [31:0] words [$];

    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Byte_Valid(Byte_Valid), .Byte_Data(Byte_Data),
        .Byte_Ready(Byte_Ready), .IMEM_W_En(IMEM_W_En), .IMEM_W_Addr(IMEM_W_Addr),
        .IMEM_W_Data(IMEM_W_Data), .Core_Hold_En(Core_Hold_En),
        .Load_Done(Load_Done), .Load_Err(Load_Err)
    );

    always #5 CLK = ~CLK;

    // memory as seen by the write port; one sample per cycle counts pulse width
    always @(negedge CLK) if (IMEM_W_En) begin
        pulses++;
        obs_mem[int'(IMEM_W_Addr)] = IMEM_W_Data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(Byte_Ready), 0);
        check({tag, "_wen"},   32'(IMEM_W_En), 0);
        check({tag, "_waddr"}, 32'(IMEM_W_Addr), 0);
        check({tag, "_wdata"}, IMEM_W_Data, 0);
        check({tag, "_hold"},  32'(Core_Hold_En), 0);
        check({tag, "_done"},  32'(Load_Done), 0);
        check({tag, "_err"},   32'(Load_Err), 0);
    endtask

    task automatic pulse_start();
        @(negedge CLK) Start = 1'b1;
        @(negedge CLK) Start = 1'b0;
    endtask

    // offer one byte after a random gap; optionally pulse Start during the gap
    task automatic send(input logic [7:0] b, input int max_gap, input bit rs);
        int t = 0;
        repeat ($urandom_range(0, max_gap)) begin
            if (rs && $urandom_range(0, 3) == 0) Start = 1'b1;
            @(negedge CLK) Start = 1'b0;
        end
        Byte_Valid = 1'b1;
        Byte_Data  = b;
        while (!Byte_Ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        check("ready_wait", 32'(t < 100), 1);
        @(posedge CLK);
        #1 Byte_Valid = 1'b0;
        Byte_Data = $urandom;
    endtask

    // full frame of the queued words; cdelta corrupts the checksum byte
    task automatic load(input logic [7:0] cdelta, input int max_gap, input bit rs);
        logic [7:0]  sum = '0;
        logic [31:0] n = 32'(words.size());
        int          p0;
        obs_mem.delete();
        pulse_start();
        p0 = pulses;
        check("start_clr_done", 32'(Load_Done), 0);
        check("start_clr_err", 32'(Load_Err), 0);
        for (int i = 0; i < 4; i++) send(n[8*i +: 8], max_gap, 0);
        foreach (words[w]) for (int k = 0; k < 4; k++) begin
            sum += words[w][8*k +: 8];
            send(words[w][8*k +: 8], max_gap, rs);
            if (k == 3) begin
                check("wen_pulse", 32'(IMEM_W_En), 1);
                check("waddr", 32'(IMEM_W_Addr), 32'(w));
                check("wdata", IMEM_W_Data, words[w]);
            end
        end
        send(sum + cdelta, max_gap, 0);
        check("done", 32'(Load_Done), 32'(cdelta == 0));
        check("err", 32'(Load_Err), 32'(cdelta != 0));
        check("hold", 32'(Core_Hold_En), 32'(cdelta != 0));
        check("ready_after", 32'(Byte_Ready), 0);
        check("pulse_count", 32'(pulses - p0), n);
        foreach (words[w]) check("mem", obs_mem.exists(w) ? obs_mem[w] : 32'hxxxxxxxx, words[w]);
    endtask

    initial begin
        int p0;
        repeat (3) @(posedge CLK);
        #1 check_idle_outputs("reset");
        @(negedge CLK) RST = 1'b1;

        words = '{32'h00000013, 32'h00500093};
        load(8'h00, 0, 0);
        load(8'hFF, 0, 0);

        // Start leaves ERROR and clears Load_Err; then an empty frame completes
        pulse_start();
        check("restart_err", 32'(Load_Err), 0);
        check("restart_hold", 32'(Core_Hold_En), 1);
        p0 = pulses;
        for (int i = 0; i < 5; i++) send(8'h00, 2, 0);
        check("n0_done", 32'(Load_Done), 1);
        check("n0_hold", 32'(Core_Hold_En), 0);
        check("n0_pulses", 32'(pulses - p0), 0);

        // DEPTH+1 words is rejected right after the length
        pulse_start();
        p0 = pulses;
        send(8'h01, 0, 0); send(8'h04, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0);
        check("big_err", 32'(Load_Err), 1);
        check("big_ready", 32'(Byte_Ready), 0);
        check("big_hold", 32'(Core_Hold_En), 1);
        repeat (3) @(negedge CLK);
        check("big_pulses", 32'(pulses - p0), 0);

        for (int r = 0; r < 5; r++) begin
            words.delete();
            repeat ($urandom_range(1, 6)) words.push_back($urandom);
            load(8'h00, TMO / 2, 1);
        end

        // stall after payload byte 5: word 0 written, word 1 not
        words = '{$urandom, $urandom};
        obs_mem.delete();
        pulse_start();
        p0 = pulses;
        send(8'h02, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0);
        for (int k = 0; k < 5; k++) send(words[k / 4][8*(k % 4) +: 8], 3, 0);
        repeat (TMO - 1) @(posedge CLK);
        #1 check("tmo_not_yet", 32'(Load_Err), 0);
        @(posedge CLK);
        #1 check("tmo_err", 32'(Load_Err), 1);
        check("tmo_ready", 32'(Byte_Ready), 0);
        check("tmo_hold", 32'(Core_Hold_En), 1);
        check("tmo_pulses", 32'(pulses - p0), 1);
        check("tmo_addr0", obs_mem.exists(0) ? obs_mem[0] : 32'hxxxxxxxx, words[0]);
        check("tmo_addr1", 32'(obs_mem.exists(1)), 0);

        // asynchronous reset in the middle of the payload
        pulse_start();
        send(8'h03, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0);
        for (int k = 0; k < 6; k++) send(8'($urandom), 0, 0);
        #2 RST = 1'b0;
        #1 check_idle_outputs("async_rst");
        @(negedge CLK) RST = 1'b1;
        words = '{$urandom, $urandom};
        load(8'h00, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for instruction memory: the write-side counterpart to the fetch stage's read-only instruction port.
- Accepts a framed byte stream (typically from a UART receiver) through a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them to the instruction memory write port, starting at word 0.
- Holds the core in reset while a load is in progress.

Parameters:
ADDR_WIDTH, 10, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH words
TIMEOUT_CYCLES, 100000, maximum idle cycles between accepted bytes before the load aborts

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
Start  input  1  single-cycle pulse; begins a new load
Byte_Valid  input  1  Byte_Data is valid
Byte_Data  input  8  stream byte
Byte_Ready  output  1  loader can accept a byte
IMEM_W_En  output  1  instruction memory write strobe, one cycle per word
IMEM_W_Addr  output  ADDR_WIDTH  word address of the write
IMEM_W_Data  output  32  word to write
Core_Hold_En  output  1  keeps the core (fetch and pipeline) in reset
Load_Done  output  1  level; last load completed with a good checksum
Load_Err  output  1  level; last load aborted

Behaviour:
- Reset (RST low, asynchronous): state IDLE; all outputs 0; internal counters, checksum and shift register cleared.
- A byte is accepted on the rising edge where Byte_Valid && Byte_Ready.
- Byte_Ready = 1 in LEN, DATA and CSUM; 0 otherwise. Bytes offered while Byte_Ready = 0 are not consumed.
- Frame format: 4-byte word count N (little-endian) -> N*4 payload bytes (little-endian words) -> 1 checksum byte.
- Checksum = sum of payload bytes mod 256. The length bytes are not included.
- Core_Hold_En = 1 in LEN, DATA, CSUM and ERROR; 0 in IDLE and DONE.
- IDLE, DONE, ERROR: Start -> LEN. The same edge clears Load_Done, Load_Err, the checksum, the word index and the timeout counter.
- Start is ignored in LEN, DATA and CSUM.
- LEN: shift in 4 bytes. On the 4th accepted byte:
  - N == 0 -> CSUM
  - N > DEPTH -> ERROR
  - otherwise -> DATA
- DATA:
  - Byte k of a word fills bits [8k+7:8k]; each byte is added to the checksum.
  - On the 4th byte of a word, IMEM_W_En pulses high for exactly one cycle, starting the cycle after that byte's acceptance edge (1-cycle registered latency).
  - During that pulse, IMEM_W_Addr = word index and IMEM_W_Data = the assembled word.
  - The word index increments after each write. After word N-1 -> CSUM.
  - Byte acceptance never stalls for the write, so a byte may be accepted in the same cycle as the IMEM_W_En pulse.
  - IMEM_W_Addr and IMEM_W_Data hold their last values when IMEM_W_En = 0.
- CSUM: one accepted byte.
  - Equal to the checksum -> DONE, Load_Done = 1.
  - Otherwise -> ERROR, Load_Err = 1.
  - Words already written are not rolled back.
- Timeout:
  - Counter is cleared on every accepted byte and on entry to LEN; it increments each cycle in LEN, DATA and CSUM.
  - Reaching TIMEOUT_CYCLES -> ERROR, Load_Err = 1.
  - An accepted byte in the same cycle wins over the timeout.
- Word index width is ADDR_WIDTH+1 internally, so N == DEPTH loads the full memory without wrap. The count compare uses the full 32-bit N.
- Reset mid-load: immediate return to IDLE with Core_Hold_En = 0. Memory contents written so far are retained.
- Load_Done and Load_Err are never both 1.

Test Plan:
- Two-word load:
  - Stimulus: Start; bytes 02 00 00 00, 13 00 00 00, 93 00 50 00, F6.
  - Required: writes addr0 = 0x00000013 and addr1 = 0x00500093, each a 1-cycle pulse one cycle after the 4th byte; then DONE with Load_Done = 1 and Core_Hold_En = 0.
- Bad checksum:
  - Stimulus: same frame, final byte F5.
  - Required: both writes still occur; ERROR, Load_Err = 1, Core_Hold_En remains 1; a new Start clears Load_Err.
- Edge lengths:
  - Stimulus A: N = 0, checksum 00. Required: DONE, no IMEM_W_En pulse.
  - Stimulus B: N = DEPTH+1 (0x00000401 with defaults). Required: ERROR on the cycle after the 4th length byte, no writes.
- Back-pressure and timeout:
  - Stimulus: random gaps in Byte_Valid below TIMEOUT_CYCLES; Start and Byte_Valid asserted while in DATA.
  - Required: identical writes and Start ignored. A stall of TIMEOUT_CYCLES after payload byte 5 -> ERROR; the word at addr0 was written, addr1 was not.
- Reset mid-DATA:
  - Stimulus: drop RST after 6 payload bytes.
  - Required: all outputs 0 immediately (asynchronous); Byte_Ready = 0; a subsequent full load completes normally from addr 0.
